// File: rtl/crc8_rx_pkg.sv
// Shared CRC-8 constants (poly x^8+x^6+x^5+x^3+1, init 0xFF), receive FSM states
// and the single-bit division step used by the serial checker.
package crc8_rx_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h69;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CRC,
    DONE
  } rx_state_t;

  function automatic logic [7:0] crc8_step(input logic [7:0] r, input logic b);
    return {r[6:0], b} ^ (r[7] ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_div_reg.sv
// CRC-8 division register. load_init with shift seeds INIT and consumes the
// incoming bit in the same cycle, so a frame's first bit is never lost.
module crc8_div_reg
  import crc8_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_init,
  input  logic       shift,
  input  logic       rx_bit,
  output logic [7:0] r
);

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= CRC8_INIT;
    end else if (shift) begin
      r <= crc8_step(load_init ? CRC8_INIT : r, rx_bit);
    end
  end

endmodule

// File: rtl/crc8_frame_checker.sv
// Serial receive-side CRC-8 checker: deserialises PAYLOAD_BYTES payload bytes,
// captures the trailing CRC byte and flags pass/fail at end of frame.
module crc8_frame_checker
  import crc8_rx_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_bit,
  input  logic       shift,
  input  logic       frame_start,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_done,
  output logic       crc_ok,
  output logic [7:0] rx_crc,
  output logic [7:0] remainder,
  output logic       busy
);

  localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

  rx_state_t  state, state_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [6:0] shreg;
  logic       crc_ok_q;
  logic       start, take, byte_end, last_byte, div_shift;

  assign start     = shift & frame_start;
  assign take      = shift & ~frame_start;
  assign byte_end  = (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == LAST_BYTE);
  // Bits arriving in IDLE/DONE without frame_start must not disturb r.
  assign div_shift = start | (take & ((state == PAYLOAD) | (state == CRC)));

  crc8_div_reg u_div (
    .clk      (clk),
    .rst      (rst),
    .load_init(start),
    .shift    (div_shift),
    .rx_bit   (rx_bit),
    .r        (remainder)
  );

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    busy       = 1'b0;
    crc_ok     = crc_ok_q;
    case (state)
      IDLE: begin
        if (start) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        busy = 1'b1;
        if (start) state_nxt = PAYLOAD;
        else if (take && byte_end && last_byte) state_nxt = CRC;
      end
      CRC: begin
        busy = 1'b1;
        if (start) state_nxt = PAYLOAD;
        else if (take && byte_end) state_nxt = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        crc_ok     = (remainder == 8'h00);
        state_nxt  = start ? PAYLOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      rx_crc     <= '0;
      crc_ok_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_valid <= 1'b0;
      if (start) begin
        bit_cnt  <= 3'd1;
        byte_cnt <= '0;
        shreg    <= {shreg[5:0], rx_bit};
        rx_crc   <= '0;
        crc_ok_q <= 1'b0;
      end else begin
        if (state == DONE) crc_ok_q <= (remainder == 8'h00);
        if (take) begin
          case (state)
            PAYLOAD: begin
              shreg   <= {shreg[5:0], rx_bit};
              bit_cnt <= bit_cnt + 3'd1;
              if (byte_end) begin
                byte_data  <= {shreg, rx_bit};
                byte_valid <= 1'b1;
                if (!last_byte) byte_cnt <= byte_cnt + 8'd1;
              end
            end
            CRC: begin
              rx_crc  <= {rx_crc[6:0], rx_bit};
              bit_cnt <= bit_cnt + 3'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Scoreboard bench: dut 0 has one payload byte (directed cases), dut 1 has four
// (random back-to-back frames against a byte-wise CRC model).
module tb_crc8_frame_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_bit;
  logic       shift [2];
  logic       fs    [2];
  logic [7:0] o_byte_data [2];
  logic       o_bv        [2];
  logic       o_done      [2];
  logic       o_ok        [2];
  logic [7:0] o_rx_crc    [2];
  logic [7:0] o_rem       [2];
  logic       o_busy      [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       ok;
    logic [7:0] crc;
    logic [7:0] rem;
    int         t;
  } frm_t;

  logic [7:0] bq [2][$];
  frm_t       fq [2][$];

  crc8_frame_checker #(.PAYLOAD_BYTES(1)) dut_a (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .shift(shift[0]), .frame_start(fs[0]),
    .byte_data(o_byte_data[0]), .byte_valid(o_bv[0]), .frame_done(o_done[0]),
    .crc_ok(o_ok[0]), .rx_crc(o_rx_crc[0]), .remainder(o_rem[0]), .busy(o_busy[0])
  );

  crc8_frame_checker #(.PAYLOAD_BYTES(4)) dut_b (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .shift(shift[1]), .frame_start(fs[1]),
    .byte_data(o_byte_data[1]), .byte_valid(o_bv[1]), .frame_done(o_done[1]),
    .crc_ok(o_ok[1]), .rx_crc(o_rx_crc[1]), .remainder(o_rem[1]), .busy(o_busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Non-augmented byte-wise form; 0x26 is 0xFF*x^8 mod P, matching the
  // transmitter's augmented (payload + 8 zero bits) CRC with init 0xFF.
  function automatic logic [7:0] model_crc(input logic [7:0] pl [4], input int nb);
    logic [7:0] c;
    c = 8'h26;
    for (int j = 0; j < nb; j++) begin
      c = c ^ pl[j];
      for (int k = 0; k < 8; k++) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h69 : 8'h00);
    end
    return c;
  endfunction

  logic [7:0] mon_b;
  frm_t       mon_f;

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (o_bv[d]) begin
          if (bq[d].size() == 0) chk($sformatf("dut%0d extra byte_valid", d), 1, 0);
          else begin
            mon_b = bq[d].pop_front();
            chk($sformatf("dut%0d byte_data", d), o_byte_data[d], mon_b);
            chk($sformatf("dut%0d busy at byte", d), o_busy[d], 1);
          end
        end
        if (o_done[d]) begin
          if (fq[d].size() == 0) chk($sformatf("dut%0d extra frame_done", d), 1, 0);
          else begin
            mon_f = fq[d].pop_front();
            chk($sformatf("dut%0d crc_ok", d), o_ok[d], mon_f.ok);
            chk($sformatf("dut%0d rx_crc", d), o_rx_crc[d], mon_f.crc);
            chk($sformatf("dut%0d remainder", d), o_rem[d], mon_f.rem);
            chk($sformatf("dut%0d busy at done", d), o_busy[d], 0);
            if (mon_f.t >= 0) chk($sformatf("dut%0d done cycle", d), cyc, mon_f.t);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the first nbits of a frame; expectations are queued only for
  // complete bytes and, if the whole frame is sent, for its frame_done.
  task automatic send_frame(input int d, input logic [7:0] pl [4], input int nb,
                            input logic [7:0] crc_tx, input int nbits,
                            input int gapmax, input logic timed);
    logic [7:0] good;
    frm_t       f;
    good = model_crc(pl, nb);
    for (int i = 0; i < nbits; i++) begin
      logic [7:0] by;
      int         k;
      if (i < nb * 8) begin
        by = pl[i / 8];
        k  = 7 - (i % 8);
      end else begin
        by = crc_tx;
        k  = 7 - (i - nb * 8);
      end
      rx_bit   = by[k];
      shift[d] = 1'b1;
      fs[d]    = (i == 0);
      tick();
      if (i == 0) begin
        for (int j = 0; j < nb && (j + 1) * 8 <= nbits; j++) bq[d].push_back(pl[j]);
        if (nbits == nb * 8 + 8) begin
          f.ok  = (crc_tx == good);
          f.crc = crc_tx;
          f.rem = good ^ crc_tx;
          f.t   = timed ? cyc + nb * 8 + 7 : -1;
          fq[d].push_back(f);
        end
      end
      shift[d] = 1'b0;
      fs[d]    = 1'b0;
      if (gapmax > 0) repeat ($urandom_range(0, gapmax)) tick();
    end
  endtask

  task automatic check_reset_state(input int d, input string tag);
    chk($sformatf("dut%0d %s byte_data", d, tag), o_byte_data[d], 8'h00);
    chk($sformatf("dut%0d %s byte_valid", d, tag), o_bv[d], 0);
    chk($sformatf("dut%0d %s frame_done", d, tag), o_done[d], 0);
    chk($sformatf("dut%0d %s crc_ok", d, tag), o_ok[d], 0);
    chk($sformatf("dut%0d %s rx_crc", d, tag), o_rx_crc[d], 8'h00);
    chk($sformatf("dut%0d %s remainder", d, tag), o_rem[d], 8'hFF);
    chk($sformatf("dut%0d %s busy", d, tag), o_busy[d], 0);
  endtask

  logic [7:0] p00 [4];
  logic [7:0] pa5 [4];
  logic [7:0] pr  [4];
  logic [7:0] crc_tx;

  initial begin
    rst    = 1'b1;
    rx_bit = 1'b0;
    shift  = '{1'b0, 1'b0};
    fs     = '{1'b0, 1'b0};
    p00    = '{8'h00, 8'h00, 8'h00, 8'h00};
    pa5    = '{8'hA5, 8'h00, 8'h00, 8'h00};
    repeat (2) tick();
    check_reset_state(0, "reset");
    check_reset_state(1, "reset");
    rst = 1'b0;
    tick();

    // Good frame 0x00 / 0x68, continuous shift, timed.
    send_frame(0, p00, 1, 8'h68, 16, 0, 1'b1);
    repeat (3) tick();
    // Bad CRC byte 0x69: remainder 0x01.
    send_frame(0, p00, 1, 8'h69, 16, 0, 1'b1);
    repeat (3) tick();
    // Same good frame with random gaps.
    send_frame(0, p00, 1, 8'h68, 16, 5, 1'b0);
    repeat (3) tick();
    // Frame aborted at bit 5, restarted by a good frame.
    send_frame(0, pa5, 1, 8'h00, 5, 0, 1'b0);
    send_frame(0, p00, 1, 8'h68, 16, 0, 1'b1);
    repeat (3) tick();

    // Reset mid-CRC: no frame_done for the interrupted frame.
    send_frame(0, p00, 1, 8'h68, 11, 0, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_state(0, "mid-crc reset");
    rst = 1'b0;
    tick();
    send_frame(0, p00, 1, 8'h68, 16, 0, 1'b1);
    repeat (3) tick();

    // Four-byte frames, back to back, with occasional stray idle bits.
    for (int i = 0; i < 50; i++) begin
      for (int j = 0; j < 4; j++) pr[j] = 8'($urandom);
      crc_tx = model_crc(pr, 4);
      if (i == 3 || $urandom_range(0, 9) == 0) crc_tx = crc_tx ^ 8'(1 << $urandom_range(0, 7));
      send_frame(1, pr, 4, crc_tx, 40, 0, 1'b1);
      if (i % 10 == 9) begin
        repeat (6) begin
          rx_bit   = 1'($urandom);
          shift[1] = 1'b1;
          fs[1]    = 1'b0;
          tick();
        end
        shift[1] = 1'b0;
      end
    end
    repeat (5) tick();

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d missing byte_valid", d), bq[d].size(), 0);
      chk($sformatf("dut%0d missing frame_done", d), fq[d].size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc8_frame_checker.md
# crc8_frame_checker

Serial receive-side CRC-8 checker for the bit-serial link whose transmitter appends a CRC-8 (polynomial x^8+x^6+x^5+x^3+1, init 0xFF) to every frame. It takes the MSB-first bit stream, deserialises a fixed number of payload bytes, streams each byte out as it completes, and captures the trailing CRC byte. At end of frame it reports pass/fail. It sits between the link bit sampler and the byte-level frame consumer. The consumer discards a frame's bytes on fail.

## Interface
- PAYLOAD_BYTES, 4: payload bytes per frame, range 1..255; the CRC byte is not counted.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- bit  in  1  serial data bit, sampled only when shift=1.
- shift  in  1  bit-valid strobe; one bit consumed per clk cycle with shift=1.
- frame_start  in  1  marks the first bit of a frame; honoured only when shift=1.
- byte_data  out  8  last completed payload byte.
- byte_valid  out  1  one-cycle pulse, byte_data valid.
- frame_done  out  1  one-cycle pulse, frame fully received.
- crc_ok  out  1  pass flag; valid from frame_done, held until next frame_start.
- rx_crc  out  8  received CRC byte, held like crc_ok.
- remainder  out  8  live division register, debug.
- busy  out  1  high from frame start until frame_done.

## Operation
- Division register r, per consumed bit: msb=r[7]; r = {r[6:0], bit} ^ (msb ? 8'h69 : 8'h00).
- Transmitter's CRC byte = r after payload plus 8 zero bits. The checker shifts payload bits and then the 8 received CRC bits through r. Frame passes iff r == 8'h00 after the last CRC bit.
- FSM states:
  - IDLE: bits with shift=1 and frame_start=0 are ignored.
  - PAYLOAD: on frame_start&shift, r is loaded with INIT and the current bit is shifted in the same cycle (the first bit is never lost). Go to PAYLOAD with bit_cnt=1, byte_cnt=0.
  - PAYLOAD: 8 bits per byte, MSB first. On the 8th bit, byte_data is registered and byte_valid pulses. After byte PAYLOAD_BYTES-1 completes, go to CRC.
  - CRC: 8 bits are shifted into both r and rx_crc. On the 8th bit, go to DONE.
  - DONE: lasts one cycle. frame_done=1, crc_ok=(r==0), busy=0. Then go to IDLE.
- frame_start&shift in PAYLOAD or CRC: the current frame is aborted with no frame_done, and a new frame starts with that bit. Bytes already emitted from the aborted frame stand.
- frame_start&shift in DONE: the new frame starts; frame_done still pulses for the old frame.
- shift=0 cycles: the FSM, r and counters hold. Gaps of any length are allowed anywhere.
- bit_cnt is 3 bits and wraps 7→0. byte_cnt is 8 bits; it is compared against PAYLOAD_BYTES-1 and never wraps.
- rst, including mid-frame:
  - state returns to IDLE;
  - r=8'hFF, byte_data=0, rx_crc=0;
  - byte_valid=0, frame_done=0, crc_ok=0, busy=0;
  - no frame_done pulse for the interrupted frame.

## Timing
- byte_valid / byte_data: asserted in the cycle after the clock edge that consumed bit 0 of the byte.
- frame_done / crc_ok / rx_crc: valid in the cycle after the edge that consumed the last CRC bit.
- busy:
  - rises the cycle after frame_start is accepted;
  - falls in the same cycle as frame_done.
- remainder: reflects r registered, with no added latency.
- Continuous shift=1: PAYLOAD_BYTES*8+8 cycles from the start bit to frame_done. Back-to-back frames need no idle bit.

## Structure
- Package crc8_rx_pkg holds:
  - CRC8_POLY=8'h69 and CRC8_INIT=8'hFF, shared with the transmit side;
  - the state enum {IDLE, PAYLOAD, CRC, DONE}.
- Sub-module crc8_div_reg: the 8-bit division register with ports load_init, shift and bit.
  - load_init&shift applies INIT and one shift in a single cycle.
  - The plain generator cannot be reused, because its reset blocks the shift in that cycle.
- Top level: FSM, bit/byte counters, byte deserialiser, rx_crc shift register, output flops.

## Test plan
- PAYLOAD_BYTES=1, continuous shift, bits 0x00 then 0x68: byte_valid with byte_data=0x00 after bit 8; frame_done with crc_ok=1, rx_crc=0x68 and remainder=0x00 exactly 16 cycles after start.
- Same frame with CRC byte 0x69: frame_done with crc_ok=0, remainder=0x01.
- Same good frame with random shift=0 gaps (0–5 cycles) between bits: identical byte_data, crc_ok=1, and no extra pulses.
- frame_start asserted at bit 5 of the 2nd frame's payload, then a full good frame: exactly one frame_done pulse for the two frames, with crc_ok=1.
- rst asserted mid-CRC: next cycle all outputs are at reset values and remainder=0xFF. No frame_done pulse. The following good frame passes.
- PAYLOAD_BYTES=4, 50 random frames back-to-back against a model (10% corrupted CRC): crc_ok matches the model on every frame, 4 byte_valid pulses per frame, and stray bits in IDLE are ignored.
